spi_master_core: RTL and testbench

- Parameterised SPI master engine; runs one full-duplex transfer of D_WIDTH bits per enable pulse.
- Configurable CPOL, CPHA and continuous (back-to-back) mode; SCLK derived from the system clock by a runtime divider.
- Sits under the memory-mapped SPI peripheral wrapper: the wrapper feeds control bits, divider and TX byte, and captures rx_data and busy.

---
 rtl/spi_master_core_pkg.sv | 18 +
 rtl/spi_master_core_sclk_gen.sv | 43 ++++
 rtl/spi_master_core.sv | 170 +++++++++++++++++
 tb/tb_spi_master_core.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_master_core_pkg.sv
// Shared state type and width helpers for the SPI master core and its divider.
package spi_master_core_pkg;

    typedef enum logic {
        READY   = 1'b0,
        EXECUTE = 1'b1
    } state_t;

    function automatic int addr_width(input int slaves);
        return (slaves > 1) ? $clog2(slaves) : 1;
    endfunction

    // Toggle counter must reach 2*D_WIDTH+1 (the end marker) without wrapping.
    function automatic int toggle_width(input int d_width);
        return $clog2(2 * d_width + 2);
    endfunction

endpackage

// File: rtl/spi_master_core_sclk_gen.sv
// SCLK half-period divider: emits one tick every ratio clocks and tracks the
// drive/sample phase (assert_data) that flips on each tick.
module spi_sclk_gen (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_load,
    input  logic       i_run,
    input  logic       i_cpha,
    input  logic [7:0] i_clk_div,
    output logic       o_tick,
    output logic       o_assert_data
);

    logic [7:0] r_ratio;
    logic [7:0] r_count;
    logic       r_assert_data;
    logic [7:0] w_div;

    assign w_div         = (i_clk_div == 8'd0) ? 8'd1 : i_clk_div;
    assign o_tick        = i_run && (r_count == r_ratio);
    assign o_assert_data = r_assert_data;

    // Count starts at ratio so the first executing cycle is already a tick
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ratio       <= 8'd1;
            r_count       <= 8'd1;
            r_assert_data <= 1'b0;
        end else if (i_load) begin
            r_ratio       <= w_div;
            r_count       <= w_div;
            r_assert_data <= ~i_cpha;
        end else if (o_tick) begin
            r_count       <= 8'd1;
            r_assert_data <= ~r_assert_data;
        end else if (i_run) begin
            r_count       <= r_count + 8'd1;
        end else begin
            r_count       <= r_count;
        end
    end

endmodule

// File: rtl/spi_master_core.sv
// Full-duplex SPI master engine, one D_WIDTH word per enable pulse with optional chaining.
// Optional build macro SPI_MOSI_TRISTATE_EN floats mosi whenever no slave is selected.
module spi_master_core
    import spi_master_core_pkg::*;
#(
    parameter int SLAVES  = 1,
    parameter int D_WIDTH = 8,
    parameter int ADDR_W  = addr_width(SLAVES)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               cpol,
    input  logic               cpha,
    input  logic               cont,
    input  logic [7:0]         clk_div,
    input  logic [ADDR_W-1:0]  addr,
    input  logic [D_WIDTH-1:0] tx_data,
    input  logic               miso,
    output logic               sclk,
    output logic [SLAVES-1:0]  ss_n,
    output logic               mosi,
    output logic               busy,
    output logic [D_WIDTH-1:0] rx_data
);

    localparam int TW = toggle_width(D_WIDTH);
    localparam logic [TW-1:0] TOG_ONE  = TW'(1);
    localparam logic [TW-1:0] TOG_FULL = TW'(2 * D_WIDTH);
    localparam logic [TW-1:0] TOG_END  = TW'(2 * D_WIDTH + 1);

    state_t             r_state;
    logic               r_busy;
    logic               r_sclk;
    logic               r_mosi;
    logic               r_cpha;
    logic               r_cont_flag;
    logic [SLAVES-1:0]  r_ss_n;
    logic [ADDR_W-1:0]  r_slave;
    logic [D_WIDTH-1:0] r_tx_buf;
    logic [D_WIDTH-1:0] r_rx_buf;
    logic [D_WIDTH-1:0] r_rx_data;
    logic [TW-1:0]      r_toggles;

    logic               w_start;
    logic               w_run;
    logic               w_tick;
    logic               w_assert_data;
    logic               w_ss_active;
    logic [TW-1:0]      w_last_rx;
    logic [ADDR_W-1:0]  w_addr;
    logic [SLAVES-1:0]  w_ss_sel;

    assign w_start     = (r_state == READY) && enable;
    assign w_run       = (r_state == EXECUTE);
    assign w_ss_active = ~(&r_ss_n);
    assign w_last_rx   = TOG_FULL + TW'(r_cpha) - TOG_ONE;
    assign w_addr      = (int'(addr) < SLAVES) ? addr : {ADDR_W{1'b0}};

    // Active-low select pattern for the latched slave index
    always_comb begin
        w_ss_sel = {SLAVES{1'b1}};
        for (int i = 0; i < SLAVES; i++) begin
            if (int'(r_slave) == i) begin
                w_ss_sel[i] = 1'b0;
            end else begin
                w_ss_sel[i] = 1'b1;
            end
        end
    end

    spi_sclk_gen u_sclk_gen (
        .i_clk         (clock),
        .i_rst_n       (reset_n),
        .i_load        (w_start),
        .i_run         (w_run),
        .i_cpha        (cpha),
        .i_clk_div     (clk_div),
        .o_tick        (w_tick),
        .o_assert_data (w_assert_data)
    );

    // Transfer FSM: shifting, SCLK edges, chaining and word completion
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= READY;
            r_busy      <= 1'b1;
            r_ss_n      <= {SLAVES{1'b1}};
            r_sclk      <= 1'b0;
            r_mosi      <= 1'b0;
            r_cpha      <= 1'b0;
            r_cont_flag <= 1'b0;
            r_slave     <= {ADDR_W{1'b0}};
            r_tx_buf    <= {D_WIDTH{1'b0}};
            r_rx_buf    <= {D_WIDTH{1'b0}};
            r_rx_data   <= {D_WIDTH{1'b0}};
            r_toggles   <= {TW{1'b0}};
        end else begin
            case (r_state)
                READY: begin
                    r_busy      <= 1'b0;
                    r_ss_n      <= {SLAVES{1'b1}};
                    r_mosi      <= 1'b0;
                    r_cont_flag <= 1'b0;
                    if (enable) begin
                        r_busy    <= 1'b1;
                        r_slave   <= w_addr;
                        r_sclk    <= cpol;
                        r_cpha    <= cpha;
                        r_tx_buf  <= tx_data;
                        r_toggles <= {TW{1'b0}};
                        r_state   <= EXECUTE;
                    end
                end
                EXECUTE: begin
                    r_busy <= 1'b1;
                    r_ss_n <= w_ss_sel;
                    if (w_tick) begin
                        if (r_toggles != TOG_END) begin
                            r_toggles <= r_toggles + TOG_ONE;
                        end
                        // Toggle 0 lands before SS is low, so toggles 1..2*D_WIDTH give a full even set
                        if ((r_toggles <= TOG_FULL) && w_ss_active) begin
                            r_sclk <= ~r_sclk;
                        end
                        if (!w_assert_data && (r_toggles < w_last_rx + TOG_ONE) && w_ss_active) begin
                            r_rx_buf <= {r_rx_buf[D_WIDTH-2:0], miso};
                        end
                        if (w_assert_data && (r_toggles < w_last_rx)) begin
                            r_mosi   <= r_tx_buf[D_WIDTH-1];
                            r_tx_buf <= {r_tx_buf[D_WIDTH-2:0], 1'b0};
                        end
                        if ((r_toggles == w_last_rx) && cont) begin
                            r_tx_buf    <= tx_data;
                            r_toggles   <= w_last_rx - TOG_FULL + TOG_ONE;
                            r_cont_flag <= 1'b1;
                        end
                        if (r_cont_flag) begin
                            r_cont_flag <= 1'b0;
                            r_busy      <= 1'b0;
                            r_rx_data   <= r_rx_buf;
                        end
                        if ((r_toggles == TOG_END) && !cont) begin
                            r_busy    <= 1'b0;
                            r_ss_n    <= {SLAVES{1'b1}};
                            r_mosi    <= 1'b0;
                            r_rx_data <= r_rx_buf;
                            r_state   <= READY;
                        end
                    end
                end
                default: begin
                    r_state <= READY;
                end
            endcase
        end
    end

    assign sclk    = r_sclk;
    assign ss_n    = r_ss_n;
    assign busy    = r_busy;
    assign rx_data = r_rx_data;

`ifdef SPI_MOSI_TRISTATE_EN
    assign mosi = (&r_ss_n) ? 1'bz : r_mosi;
`else
    assign mosi = r_mosi;
`endif

endmodule

// File: tb/tb_spi_master_core.sv
// Self-checking bench for spi_master_core: vector table of single-word transfers,
// plus hand-written continuous-mode and mid-transfer reset sequences.
module tb_spi_master_core;

    logic       clock;
    logic       reset_n;
    logic       enable;
    logic       cpol;
    logic       cpha;
    logic       cont;
    logic [7:0] clk_div;
    logic [1:0] addr;
    logic [7:0] tx_data;
    logic       miso;
    logic       sclk;
    logic [2:0] ss_n;
    logic       mosi;
    logic       busy;
    logic [7:0] rx_data;
    logic [1:0] miso_mode;

`ifdef SPI_MOSI_TRISTATE_EN
    localparam logic MOSI_IDLE = 1'bz;
`else
    localparam logic MOSI_IDLE = 1'b0;
`endif

    typedef struct {
        logic       cpol;
        logic       cpha;
        logic [7:0] div;
        logic [7:0] tx;
        logic [1:0] mmode;
        logic [1:0] addr;
        logic [7:0] exp_rx;
        logic [2:0] exp_ss;
    } vec_t;

    vec_t       vecs[5];
    logic [7:0] exp_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;

    spi_master_core #(.SLAVES(3), .D_WIDTH(8)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .enable  (enable),
        .cpol    (cpol),
        .cpha    (cpha),
        .cont    (cont),
        .clk_div (clk_div),
        .addr    (addr),
        .tx_data (tx_data),
        .miso    (miso),
        .sclk    (sclk),
        .ss_n    (ss_n),
        .mosi    (mosi),
        .busy    (busy),
        .rx_data (rx_data)
    );

    // miso source: 0 = loopback of mosi, 1 = tied high, otherwise tied low
    assign miso = (miso_mode == 2'd0) ? mosi : (miso_mode == 2'd1);

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] pop_exp();
        if (exp_q.size() == 0) return 8'hxx;
        return exp_q.pop_front();
    endfunction

    task automatic run_xfer(input vec_t v);
        int         cyc, busy_cnt, edges, rises, lvl, bad_lvl, nbits, ratio;
        logic       prev, samp_lvl;
        logic [7:0] got_tx;
        logic [2:0] ss_mid;
        ratio     = (v.div == 8'd0) ? 1 : int'(v.div);
        cpol      = v.cpol;
        cpha      = v.cpha;
        clk_div   = v.div;
        tx_data   = v.tx;
        miso_mode = v.mmode;
        addr      = v.addr;
        cont      = 1'b0;
        samp_lvl  = ~(v.cpol ^ v.cpha);
        exp_q.push_back(v.exp_rx);
        @(negedge clock); enable = 1'b1;
        @(negedge clock); enable = 1'b0;
        prev = sclk; cyc = 0; busy_cnt = 0; edges = 0; rises = 0;
        lvl = 0; bad_lvl = 0; nbits = 0; got_tx = 8'h00; ss_mid = 3'b111;
        while (busy === 1'b1 && cyc < 3000) begin
            busy_cnt++;
            @(negedge clock);
            cyc++;
            lvl++;
            if (sclk !== prev) begin
                if (edges > 0 && lvl != ratio) bad_lvl++;
                lvl = 0;
                edges++;
                if (sclk === 1'b1) rises++;
                if (sclk === samp_lvl) begin
                    got_tx = {got_tx[6:0], mosi};
                    nbits++;
                end
                if (edges == 1) ss_mid = ss_n;
                prev = sclk;
            end
        end
        chk("xfer_done",   {31'd0, busy},   32'd0);
        chk("rx_data",     {24'd0, rx_data}, {24'd0, pop_exp()});
        chk("mosi_word",   {24'd0, got_tx}, {24'd0, v.tx});
        chk("mosi_bits",   nbits,   32'd8);
        chk("sclk_edges",  edges,   32'd16);
        chk("sclk_rises",  rises,   32'd8);
        chk("half_period", bad_lvl, 32'd0);
        chk("ss_active",   {29'd0, ss_mid}, {29'd0, v.exp_ss});
        chk("busy_cycles", busy_cnt, 17 * ratio + 1);
        chk("ss_idle",     {29'd0, ss_n}, 32'd7);
        chk("sclk_idle",   {31'd0, sclk}, {31'd0, v.cpol});
        chk("mosi_idle",   {31'd0, mosi}, {31'd0, MOSI_IDLE});
    endtask

    initial begin
        int          cyc, dips, edges, nbits, ss_bad;
        logic        prev, after_dip, dip_ok;
        logic [15:0] word;

        vecs[0] = '{1'b0, 1'b0, 8'd0, 8'hA5, 2'd0, 2'd0, 8'hA5, 3'b110};
        vecs[1] = '{1'b1, 1'b1, 8'd4, 8'h3C, 2'd1, 2'd1, 8'hFF, 3'b101};
        vecs[2] = '{1'b0, 1'b1, 8'd2, 8'h96, 2'd0, 2'd2, 8'h96, 3'b011};
        vecs[3] = '{1'b1, 1'b0, 8'd1, 8'h5B, 2'd2, 2'd3, 8'h00, 3'b110};
        vecs[4] = '{1'b0, 1'b0, 8'd3, 8'hFF, 2'd0, 2'd0, 8'hFF, 3'b110};

        reset_n = 1'b0; enable = 1'b0; cpol = 1'b0; cpha = 1'b0; cont = 1'b0;
        clk_div = 8'd0; addr = 2'd0; tx_data = 8'h00; miso_mode = 2'd0;
        repeat (3) @(negedge clock);
        chk("rst_busy", {31'd0, busy}, 32'd1);
        chk("rst_ss_n", {29'd0, ss_n}, 32'd7);
        chk("rst_sclk", {31'd0, sclk}, 32'd0);
        chk("rst_rx",   {24'd0, rx_data}, 32'd0);
        chk("rst_mosi", {31'd0, mosi}, {31'd0, MOSI_IDLE});
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        chk("ready_busy", {31'd0, busy}, 32'd0);

        for (int i = 0; i < 5; i++) run_xfer(vecs[i]);

        // Continuous mode: two chained words, tx_data swapped mid-word, cont dropped after the dip
        cpol = 1'b0; cpha = 1'b0; clk_div = 8'd1; tx_data = 8'h12;
        miso_mode = 2'd0; addr = 2'd0; cont = 1'b1;
        exp_q.push_back(8'h12);
        exp_q.push_back(8'h34);
        @(negedge clock); enable = 1'b1;
        @(negedge clock); enable = 1'b0;
        prev = sclk; cyc = 0; dips = 0; edges = 0; nbits = 0; ss_bad = 0;
        word = 16'h0000; after_dip = 1'b0; dip_ok = 1'b0;
        while (dips < 2 && cyc < 3000) begin
            @(negedge clock);
            cyc++;
            if (cyc == 4) tx_data = 8'h34;
            if (sclk !== prev) begin
                edges++;
                if (sclk === 1'b1) begin
                    word = {word[14:0], mosi};
                    nbits++;
                end
                prev = sclk;
            end
            if (after_dip) begin
                dip_ok    = (busy === 1'b1);
                after_dip = 1'b0;
            end
            if (busy !== 1'b1) begin
                dips++;
                if (dips == 1) begin
                    chk("cont_rx_word1", {24'd0, rx_data}, {24'd0, pop_exp()});
                    chk("cont_ss_at_dip", {29'd0, ss_n}, 32'd6);
                    cont      = 1'b0;
                    after_dip = 1'b1;
                end
            end else if (cyc >= 2 && ss_n !== 3'b110) begin
                ss_bad++;
            end
        end
        chk("cont_done",     dips,  32'd2);
        chk("cont_dip_len",  {31'd0, dip_ok}, 32'd1);
        chk("cont_bits",     nbits, 32'd16);
        chk("cont_mosi",     {16'd0, word}, 32'h1234);
        chk("cont_edges",    edges, 32'd32);
        chk("cont_ss_held",  ss_bad, 32'd0);
        chk("cont_rx_word2", {24'd0, rx_data}, {24'd0, pop_exp()});
        chk("cont_ss_idle",  {29'd0, ss_n}, 32'd7);

        // Asynchronous reset in the middle of a transfer
        cpol = 1'b0; cpha = 1'b0; clk_div = 8'd2; tx_data = 8'hC3;
        miso_mode = 2'd0; addr = 2'd1;
        @(negedge clock); enable = 1'b1;
        @(negedge clock); enable = 1'b0;
        repeat (10) @(negedge clock);
        chk("abort_pre_busy", {31'd0, busy}, 32'd1);
        chk("abort_pre_ss",   {29'd0, ss_n}, 32'd5);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd1);
        chk("abort_ss_n", {29'd0, ss_n}, 32'd7);
        chk("abort_sclk", {31'd0, sclk}, 32'd0);
        chk("abort_rx",   {24'd0, rx_data}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        chk("abort_ready", {31'd0, busy}, 32'd0);
        run_xfer('{1'b0, 1'b0, 8'd1, 8'h5A, 2'd0, 2'd0, 8'h5A, 3'b110});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
